// File: rtl/life_pkg.sv
// Shared types for the Game-of-Life generation controller.
package life_pkg;

    localparam int GRID_W = 64;

    typedef logic [GRID_W-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSED = 2'd1,
        RUN    = 2'd2,
        HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/tick_divider.sv
// Counts enabled cycles and raises tick for the one cycle where the count
// reaches TICK_DIV-1; clr forces the count back to zero and masks tick.
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Generation controller: owns the grid register, loads it, commits evolve
// results on run ticks or single steps, and halts on extinction/still/period-2.
module life_sequencer
    import life_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      seed,
    input  logic [63:0]      rand_grid,
    input  logic [63:0]      grid_next,
    input  logic             load_seed,
    input  logic             load_rand,
    input  logic             run,
    input  logic             step,
    output logic [63:0]      grid,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state,
    output logic             evolve,
    output logic             extinct,
    output logic             stable,
    output logic             osc
);

    state_t           state_q;
    grid_t            grid_q;
    grid_t            prev_q;
    logic [GEN_W-1:0] gen_q;

    logic  load_any;
    grid_t load_src;
    logic  run_en;
    logic  tick_hit;
    logic  commit;
    logic  hit_extinct;
    logic  hit_stable;
    logic  hit_osc;

    assign load_any = load_seed | load_rand;
    assign load_src = load_seed ? seed : rand_grid;
    assign run_en   = (state_q == RUN) && run;

    // The divider only counts while RUN is sustained; any load or exit resets it.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (load_any || !run_en),
        .en    (run_en),
        .tick  (tick_hit)
    );

    assign commit = !load_any && (((state_q == PAUSED) && step) || tick_hit);

    // Halt causes are mutually exclusive by construction: extinct > stable > osc.
    assign hit_extinct = (grid_next == '0);
    assign hit_stable  = !hit_extinct && (grid_next == grid_q);
    assign hit_osc     = !hit_extinct && !hit_stable &&
                         (grid_next == prev_q) && (prev_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            prev_q  <= '0;
            gen_q   <= '0;
            evolve  <= 1'b0;
            extinct <= 1'b0;
            stable  <= 1'b0;
            osc     <= 1'b0;
        end else begin
            evolve <= 1'b0;
            if (load_any) begin
                state_q <= PAUSED;
                grid_q  <= load_src;
                prev_q  <= '0;
                gen_q   <= '0;
                extinct <= 1'b0;
                stable  <= 1'b0;
                osc     <= 1'b0;
            end else if (commit) begin
                grid_q  <= grid_next;
                prev_q  <= grid_q;
                gen_q   <= (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                evolve  <= 1'b1;
                extinct <= hit_extinct;
                stable  <= hit_stable;
                osc     <= hit_osc;
                if (hit_extinct || hit_stable || hit_osc) begin
                    state_q <= HALT;
                end
            end else begin
                case (state_q)
                    PAUSED: if (run)  state_q <= RUN;
                    RUN:    if (!run) state_q <= PAUSED;
                    default: ;
                endcase
            end
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign state     = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a reference Game-of-Life datapath
// supplying grid_next and hand-computed expectations for every check.
module tb_life_sequencer;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 16;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

    logic             clk;
    logic             reset;
    logic [63:0]      seed;
    logic [63:0]      rand_grid;
    logic [63:0]      grid_next;
    logic             load_seed;
    logic             load_rand;
    logic             run;
    logic             step;
    logic [63:0]      grid;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       state;
    logic             evolve;
    logic             extinct;
    logic             stable;
    logic             osc;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    life_sequencer #(
        .TICK_DIV (TICK_DIV),
        .GEN_W    (GEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .rand_grid (rand_grid),
        .grid_next (grid_next),
        .load_seed (load_seed),
        .load_rand (load_rand),
        .run       (run),
        .step      (step),
        .grid      (grid),
        .gen_count (gen_count),
        .state     (state),
        .evolve    (evolve),
        .extinct   (extinct),
        .stable    (stable),
        .osc       (osc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference evolve datapath, non-wrapping edges.
    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] r;
        int          n;
        r = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && row + dr >= 0 && row + dr < 8 &&
                            col + dc >= 0 && col + dc < 8) begin
                            n += int'(g[(row + dr) * 8 + col + dc]);
                        end
                    end
                end
                r[row * 8 + col] = g[row * 8 + col] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return r;
    endfunction

    always_comb grid_next = life_step(grid);

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load_seed(input logic [63:0] value);
        seed      = value;
        load_seed = 1'b1;
        cycle();
        load_seed = 1'b0;
    endtask

    task automatic wait_evolve(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!evolve && n < 16);
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, {61'd0, extinct, stable, osc}, {61'd0, exp});
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        seed      = '0;
        rand_grid = '0;
        load_seed = 1'b0;
        load_rand = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        cycle();
        cycle();
        check("reset_state", state, 0);
        check("reset_grid", grid, 0);
        check("reset_gen", gen_count, 0);
        check("reset_evolve", evolve, 0);
        check_flags("reset_flags", 3'b000);
        reset = 1'b1;
        cycle();

        // IDLE ignores step and run
        step = 1'b1;
        run  = 1'b1;
        cycle();
        cycle();
        check("idle_state", state, 0);
        check("idle_grid", grid, 0);
        check("idle_gen", gen_count, 0);
        step = 1'b0;
        run  = 1'b0;

        // Blinker: two single steps end in period-2 halt
        do_load_seed(BLINK_H);
        check("blink_load_state", state, 1);
        check("blink_load_grid", grid, BLINK_H);
        step = 1'b1;
        cycle();
        step = 1'b0;
        check("blink_step1_grid", grid, BLINK_V);
        check("blink_step1_gen", gen_count, 1);
        check("blink_step1_evolve", evolve, 1);
        check("blink_step1_state", state, 1);
        cycle();
        check("blink_evolve_drop", evolve, 0);
        step = 1'b1;
        cycle();
        step = 1'b0;
        check("blink_step2_grid", grid, BLINK_H);
        check("blink_step2_gen", gen_count, 2);
        check("blink_step2_state", state, 3);
        check_flags("blink_osc_flags", 3'b001);
        step = 1'b1;
        run  = 1'b1;
        cycle();
        cycle();
        step = 1'b0;
        run  = 1'b0;
        check("halt_grid_frozen", grid, BLINK_H);
        check("halt_gen_frozen", gen_count, 2);
        check("halt_state", state, 3);
        check_flags("halt_flags_hold", 3'b001);

        // Block under RUN: stable after TICK_DIV cycles
        do_load_seed(BLOCK);
        check_flags("block_load_clears", 3'b000);
        check("block_load_state", state, 1);
        run = 1'b1;
        cycle();
        check("block_run_state", state, 2);
        wait_evolve(n);
        check("block_first_commit_latency", n, TICK_DIV);
        check("block_gen", gen_count, 1);
        check("block_state", state, 3);
        check("block_grid", grid, BLOCK);
        check_flags("block_stable_flags", 3'b010);
        run = 1'b0;

        // Both loads at once: seed wins
        seed      = BLINK_V;
        rand_grid = SINGLE;
        load_seed = 1'b1;
        load_rand = 1'b1;
        cycle();
        load_seed = 1'b0;
        load_rand = 1'b0;
        check("load_priority_grid", grid, BLINK_V);

        // Single cell from LFSR dies out
        load_rand = 1'b1;
        cycle();
        load_rand = 1'b0;
        check("rand_load_grid", grid, SINGLE);
        run = 1'b1;
        cycle();
        wait_evolve(n);
        check("rand_commit_latency", n, TICK_DIV);
        check("rand_grid_empty", grid, 0);
        check("rand_state", state, 3);
        check("rand_gen", gen_count, 1);
        check_flags("rand_extinct_flags", 3'b100);
        run = 1'b0;

        // Load coinciding with the commit tick wins, no evolve
        do_load_seed(BLINK_H);
        run = 1'b1;
        cycle();
        for (int i = 1; i < TICK_DIV; i++) begin
            cycle();
            check("collide_pre_evolve", evolve, 0);
        end
        seed      = BLOCK;
        load_seed = 1'b1;
        cycle();
        load_seed = 1'b0;
        run       = 1'b0;
        check("collide_grid", grid, BLOCK);
        check("collide_gen", gen_count, 0);
        check("collide_state", state, 1);
        check("collide_evolve", evolve, 0);
        cycle();
        check("collide_after_evolve", evolve, 0);
        check("collide_after_state", state, 1);

        // Glider runs three generations, then asynchronous reset
        do_load_seed(GLIDER);
        run = 1'b1;
        cycle();
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'd3);
        for (int g = 0; g < 3; g++) begin
            wait_evolve(n);
            check("glider_period", n, TICK_DIV);
            check("glider_gen", gen_count, exp_q.pop_front());
            check("glider_state", state, 2);
        end
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_state", state, 0);
        check("async_reset_grid", grid, 0);
        check("async_reset_gen", gen_count, 0);
        check("async_reset_evolve", evolve, 0);
        check_flags("async_reset_flags", 3'b000);
        run = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("post_reset_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Generation controller for the 8x8 Game-of-Life datapath. Owns the 64-bit grid register and loads it from the external seed or the LFSR word. Presents the grid to the combinational evolve datapath and commits its result on run ticks or single steps. Counts generations and halts on extinction, still life or period-2 oscillation; replaces the free-running switch FSM plus mux arrangement.

Parameters:
TICK_DIV, 4, clock cycles between generations in RUN (>=1)
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
seed  in  64  user seed grid; bit index = row*8+col
rand_grid  in  64  current LFSR word
grid_next  in  64  datapath evolve result of grid (combinational)
load_seed  in  1  pulse: load seed
load_rand  in  1  pulse: load rand_grid
run  in  1  level: free-run generations
step  in  1  pulse: advance one generation while paused
grid  out  64  current grid, drives datapath and display
gen_count  out  GEN_W  generations since last load
state  out  2  IDLE=0, PAUSED=1, RUN=2, HALT=3
evolve  out  1  1-cycle strobe, high in the cycle a generation commits
extinct  out  1  halt cause: grid became empty
stable  out  1  halt cause: grid_next == grid
osc  out  1  halt cause: grid_next == previous grid

Behaviour:
- Reset (reset=0, asynchronous): grid=0, prev=0, gen_count=0, tick counter=0, state=IDLE, evolve/extinct/stable/osc=0.
- Input priority per cycle: load_seed > load_rand > step > run.
- Load in any state: next edge grid<=source, prev<=0, gen_count<=0, tick<=0, flags cleared, state<=PAUSED. A load simultaneous with a commit wins; no commit occurs.
- IDLE: only a load leaves it; run and step are ignored.
- PAUSED: step=1 commits at that edge, so 1-cycle latency. run=1 with no step moves to RUN with tick=0.
- RUN: tick increments each cycle. At tick==TICK_DIV-1, commit and tick<=0. First commit occurs TICK_DIV cycles after entering RUN. run=0 moves to PAUSED, tick<=0, no commit that cycle. step is ignored in RUN.
- Commit:
  - grid<=grid_next, prev<=grid.
  - gen_count<=gen_count+1, saturating at all-ones.
  - evolve=1 in the commit cycle, registered with the commit.
- Halt check on the commit values, priority extinct > stable > osc:
  - grid_next==0: extinct.
  - grid_next==grid: stable.
  - grid_next==prev and prev!=0: osc.
  - Any hit: set that single flag and go to HALT.
- HALT: grid frozen; run and step ignored; only a load exits. Flags hold until a load or reset.
- Reset mid-run: everything returns to reset values immediately, independent of clk.
- Exactly one halt flag may be 1 at any time; all are 0 outside HALT.

Decomposition:
- Package life_pkg: state enum typedef (IDLE/PAUSED/RUN/HALT), GRID_W=64 constant, grid_t typedef logic[63:0].
- Sub-module tick_divider (TICK_DIV counter with clear and enable, 1-cycle tick output) is natural.
- Halt comparators stay inline.

Test Plan:
- Reset, then step and run with no load -> state stays IDLE, grid=0, gen_count=0.
- load_seed with 0x0000_0000_1C00_0000 (horizontal blinker); step -> grid=0x0000_0008_0808_0000, gen_count=1, evolve pulses once. Step again -> grid=0x0000_0000_1C00_0000, gen_count=2, state=HALT, osc=1.
- load_seed 0x0000_0018_1800_0000 (2x2 block), run=1, TICK_DIV=4 -> first commit 4 cycles later, stable=1, state=HALT, gen_count=1, grid unchanged.
- load_rand with rand_grid=0x0000_0000_0800_0000 (single cell), run=1 -> one commit, grid=0, extinct=1, HALT.
- In RUN, assert load_seed on the same cycle tick reaches TICK_DIV-1 -> grid=seed, gen_count=0, state=PAUSED, no evolve pulse.
- Deassert reset mid-RUN after 3 generations -> all outputs return to reset values asynchronously.
